// File: rtl/clk_div_monitor_pkg.sv
// ============================================================================
// Module      : clk_div_monitor_pkg
// Description : Shared types and constants for the divided-clock strobe
//               monitor (FSM state encoding, drop-counter width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_monitor_pkg;

    // Monitor FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        TIMEOUT = 3'd4
    } state_e;

    // Width of the optional backpressure drop counter
    localparam int DROP_CNT_WIDTH = 16;

endpackage : clk_div_monitor_pkg

`default_nettype wire

// File: rtl/clk_div_monitor_edge.sv
// ============================================================================
// Module      : clk_div_monitor_edge
// Description : Rising-edge detector for a strobe synchronous to clk_i.
//               Keeps the previous sample in a register; a strobe held high
//               yields a single-cycle event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic r_q;

    // Previous-cycle sample of the strobe
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d_i;
        end
    end

    assign edge_o = d_i & ~r_q;

endmodule : clk_div_monitor_edge

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module      : clk_div_monitor
// Description : Measures the period of a divided-clock strobe in clk_i
//               cycles, reports it over valid/ready, and flags lock,
//               mismatch against an expected ratio, and strobe loss.
//               Optional macro CLK_DIV_MONITOR_STATS_EN adds dropped_o, a
//               saturating count of measurements lost to backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      pulse_i,
    input  logic [CNT_WIDTH-1:0]      expected_i,
    output logic [CNT_WIDTH-1:0]      ratio_o,
    output logic                      ratio_valid_o,
    input  logic                      ratio_ready_i,
    output logic                      locked_o,
    output logic                      mismatch_o,
    output logic                      timeout_o
`ifdef CLK_DIV_MONITOR_STATS_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] dropped_o
`endif
);

    localparam int                   c_eq_w     = $clog2(LOCK_COUNT + 1);
    localparam logic [c_eq_w-1:0]    c_lock_max = c_eq_w'(LOCK_COUNT);
    localparam logic [c_eq_w-1:0]    c_eq_one   = c_eq_w'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_timeout  = CNT_WIDTH'(TIMEOUT);

    generate
        if ((TIMEOUT < 3) || (TIMEOUT > (2 ** CNT_WIDTH) - 1)) begin : g_bad_timeout
            $error("clk_div_monitor: TIMEOUT must be in 3 .. 2**CNT_WIDTH-1");
        end
        if (LOCK_COUNT < 1) begin : g_bad_lock_count
            $error("clk_div_monitor: LOCK_COUNT must be at least 1");
        end
    endgenerate

    // The parameter TIMEOUT hides the imported state literal of the same
    // name, so that state is always referenced through the package scope.
    state_e                r_state, w_state_d;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
    logic [CNT_WIDTH-1:0]  r_prev, w_prev_d;
    logic [CNT_WIDTH-1:0]  r_ratio, w_ratio_d;
    logic [c_eq_w-1:0]     r_eq, w_eq_d;
    logic                  r_valid, w_valid_d;
    logic                  r_mismatch, w_mismatch_d;
    logic                  r_locked, r_timeout;
    logic                  w_edge, w_meas, w_same;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [c_eq_w-1:0]     w_eq_meas;

    clk_div_monitor_edge u_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pulse_i),
        .edge_o (w_edge)
    );

    // eq count of zero means no previous measurement to compare against
    assign w_same    = (r_eq != '0) && (r_cnt == r_prev);
    assign w_eq_meas = !w_same ? c_eq_one :
                       ((r_eq == c_lock_max) ? r_eq : r_eq + c_eq_one);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_cnt_one;

    // Next-state, period counting and lock tracking
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_prev_d     = r_prev;
        w_eq_d       = r_eq;
        w_mismatch_d = r_mismatch;
        w_meas       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_d = SYNC;
            end
            SYNC: begin
                if (w_edge) begin
                    w_cnt_d   = c_cnt_one;
                    w_state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (w_edge) begin
                    // Edge wins over a simultaneous timeout
                    w_meas       = 1'b1;
                    w_cnt_d      = c_cnt_one;
                    w_prev_d     = r_cnt;
                    w_eq_d       = w_eq_meas;
                    w_mismatch_d = (r_cnt != expected_i);
                    w_state_d    = (w_eq_meas == c_lock_max) ? LOCKED : MEASURE;
                end else if (r_cnt == c_timeout) begin
                    w_eq_d    = '0;
                    w_state_d = clk_div_monitor_pkg::TIMEOUT;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            clk_div_monitor_pkg::TIMEOUT: begin
                if (w_edge) begin
                    w_cnt_d   = c_cnt_one;
                    w_state_d = MEASURE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        if (!en_i) begin
            w_state_d    = IDLE;
            w_cnt_d      = '0;
            w_eq_d       = '0;
            w_mismatch_d = 1'b0;
        end
    end

    // Output holding register: a busy register drops new measurements
    always_comb begin
        w_valid_d = r_valid;
        w_ratio_d = r_ratio;
        if (w_meas && (!r_valid || ratio_ready_i)) begin
            w_valid_d = 1'b1;
            w_ratio_d = r_cnt;
        end else if (r_valid && ratio_ready_i) begin
            w_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_eq       <= '0;
            r_ratio    <= '0;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_prev     <= w_prev_d;
            r_eq       <= w_eq_d;
            r_ratio    <= w_ratio_d;
            r_valid    <= w_valid_d;
            r_mismatch <= w_mismatch_d;
            r_locked   <= (w_state_d == LOCKED);
            r_timeout  <= (w_state_d == clk_div_monitor_pkg::TIMEOUT);
        end
    end

    assign ratio_o       = r_ratio;
    assign ratio_valid_o = r_valid;
    assign locked_o      = r_locked;
    assign mismatch_o    = r_mismatch;
    assign timeout_o     = r_timeout;

`ifdef CLK_DIV_MONITOR_STATS_EN
    localparam logic [DROP_CNT_WIDTH-1:0] c_drop_one = DROP_CNT_WIDTH'(1);

    logic                      w_drop;
    logic [DROP_CNT_WIDTH-1:0] r_dropped;

    assign w_drop = w_meas & r_valid & ~ratio_ready_i;

    // Saturating count of measurements lost to backpressure
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            r_dropped <= '0;
        end else if (w_drop && !(&r_dropped)) begin
            r_dropped <= r_dropped + c_drop_one;
        end
    end

    assign dropped_o = r_dropped;
`endif

endmodule : clk_div_monitor

`default_nettype wire
